output_deskew_buffer: RTL

Realigns the skewed result wavefront leaving the systolic array into row-aligned words. It is the counterpart of the input skew stage on the array's output side. Lane j of the array's output edge arrives j cycles after lane 0, so the block delays lane j by N-1-j stages. It also tracks per-lane valids, counts rows per tile and flags misaligned wavefronts.

---
 rtl/output_deskew_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/output_deskew_buffer.sv
// rtl/output_deskew_buffer.sv - realigns the skewed systolic-array output wavefront into row-aligned words
module output_deskew_buffer #(
  parameter int N          = 4,
  parameter int data_width = 16,
  parameter int ROWS       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N*data_width-1:0]    skewed_input,
  input  logic [N-1:0]               skewed_valid,
  input  logic                       clear_error,
  output logic [N*data_width-1:0]    aligned_output,
  output logic                       aligned_valid,
  output logic                       aligned_last,
  output logic [$clog2(ROWS>1?ROWS:2)-1:0] row_index,
  output logic                       align_error
);

  localparam int RW = $clog2(ROWS > 1 ? ROWS : 2);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  // Delayed lane data/valid as seen at the alignment point (input of the output registers).
  logic [N-1:0][data_width-1:0] dly_data;
  logic [N-1:0]                 dly_valid;

  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_nodly
      assign dly_data[j]  = skewed_input[j*data_width +: data_width];
      assign dly_valid[j] = skewed_valid[j];
    end else begin : g_dly
      logic [data_width-1:0] data_q [D];
      logic [D-1:0]          valid_q;

      // Lane delay chain: data and valid shift together so they stay paired; frozen when enable=0.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) begin
            data_q[i] <= '0;
          end
          valid_q <= '0;
        end else if (enable) begin
          data_q[0]  <= skewed_input[j*data_width +: data_width];
          valid_q[0] <= skewed_valid[j];
          for (int i = 1; i < D; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign dly_data[j]  = data_q[D-1];
      assign dly_valid[j] = valid_q[D-1];
    end
  end

  logic all_valid;
  logic mixed_valid;

  assign all_valid   = &dly_valid;
  assign mixed_valid = (|dly_valid) & ~all_valid;

  logic [N*data_width-1:0] out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [RW-1:0]           row_q, row_d;
  logic [RW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;

  // Next-state for the output stage: a beat is emitted only when every lane agrees it is valid.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    row_d   = row_q;
    cnt_d   = cnt_q;
    if (enable) begin
      out_d = dly_data;
      if (all_valid) begin
        valid_d = 1'b1;
        row_d   = cnt_q;
        last_d  = (cnt_q == LAST_ROW);
        cnt_d   = (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
      end
    end
    // Set has priority over a simultaneous clear so a fresh mismatch is never lost.
    err_d = (enable & mixed_valid) | (err_q & ~clear_error);
  end

  // Output registers, row counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign aligned_output = out_q;
  assign aligned_valid  = valid_q;
  assign aligned_last   = last_q;
  assign row_index      = row_q;
  assign align_error    = err_q;

endmodule
